// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int unsigned N_IN_DEF = 5;
   localparam int unsigned SETTLE_W = 4;

   // Bit positions of the circuit inputs within stim
   localparam int unsigned STIM_A = 4;
   localparam int unsigned STIM_B = 3;
   localparam int unsigned STIM_C = 2;
   localparam int unsigned STIM_D = 1;
   localparam int unsigned STIM_E = 0;

endpackage

// File: rtl/tt_sweeper_if.sv
// Stimulus/response bundle between the sweeper and its controller.
interface tt_sweeper_if #(
   parameter int unsigned N_IN = 5
) ();
   localparam int unsigned NV = 2**N_IN;

   logic            start;
   logic            y;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic [NV-1:0]   result;
   logic [NV-1:0]   golden;
   logic            fail;
   logic [N_IN:0]   mismatch_cnt;

   modport master (
      output start, y, golden,
      input  stim, busy, done, result, fail, mismatch_cnt
   );

   modport slave (
      input  start, y, golden,
      output stim, busy, done, result, fail, mismatch_cnt
   );
endinterface

// File: rtl/tt_cmp.sv
// Golden-word comparator: sticky fail flag and mismatch counter (used with TT_CHECK_EN).
module tt_cmp #(
   parameter int unsigned N_IN = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          y_i,
   input  logic          exp_i,
   input  logic          sample_i,
   input  logic          clear_i,
   output logic          fail_o,
   output logic [N_IN:0] mismatch_cnt_o
);
   logic          fail_q;
   logic [N_IN:0] cnt_q;

   // Count can reach 2**N_IN at most, which fits N_IN+1 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_q <= 1'b0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         fail_q <= 1'b0;
         cnt_q  <= '0;
      end else if (sample_i && (y_i != exp_i)) begin
         fail_q <= 1'b1;
         cnt_q  <= cnt_q + (N_IN+1)'(1);
      end
   end

   assign fail_o         = fail_q;
   assign mismatch_cnt_o = cnt_q;
endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive input sweeper and truth-table capture for a combinational circuit.
// Define TT_CHECK_EN to add on-chip golden-word comparison.
module tt_sweeper
   import tt_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEF,
   parameter int unsigned SETTLE = 1
) (
   input logic         clk,
   input logic         rst_n,
   tt_sweeper_if.slave bus
);
   localparam int unsigned NV = 2**N_IN;
   localparam logic [N_IN-1:0]     LAST_IDX    = N_IN'(NV-1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE-1);

   state_e              state_q, state_d;
   logic [N_IN-1:0]     idx_q, idx_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [NV-1:0]       result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                clear_c, sample_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // idx doubles as the registered stim vector, so it holds through DONE/IDLE
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      result_d = result_q;
      clear_c  = 1'b0;
      sample_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = DRIVE;
               idx_d    = '0;
               settle_d = '0;
               result_d = '0;
               clear_c  = 1'b1;
            end
         end
         DRIVE: begin
            settle_d = settle_q + SETTLE_W'(1);
            if (settle_q == SETTLE_LAST) state_d = SAMPLE;
         end
         SAMPLE: begin
            sample_c        = 1'b1;
            result_d[idx_q] = bus.y;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d    = idx_q + N_IN'(1);
               settle_d = '0;
               state_d  = DRIVE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   assign bus.stim   = idx_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

`ifdef TT_CHECK_EN
   tt_cmp #(.N_IN(N_IN)) u_cmp (
      .clk            (clk),
      .rst_n          (rst_n),
      .y_i            (bus.y),
      .exp_i          (bus.golden[idx_q]),
      .sample_i       (sample_c),
      .clear_i        (clear_c),
      .fail_o         (bus.fail),
      .mismatch_cnt_o (bus.mismatch_cnt)
   );
`else
   logic unused_golden;
   assign unused_golden    = ^{bus.golden, sample_c, clear_c};
   assign bus.fail         = 1'b0;
   assign bus.mismatch_cnt = '0;
`endif
endmodule
